serial_max_tracker: RTL and testbench
=====================================

// Module: serial_max_tracker
// PURPOSE
//  Sequential counterpart of the team's parallel 4-input max comparator.
//  Accepts a frame of N unsigned samples one per handshake and tracks the running maximum.
//  Emits the maximum, a "greatest" flag per sample position (all positions tied at max are
//  flagged) and the lowest winning index. Sits between a sample stream source and the
//  result consumer; valid/ready on both sides.
// PARAMETERS
//  WIDTH  4  bit width of each unsigned sample
//  N      4  samples per frame; N >= 2
// PORTS
//  clk        in   1          single clock, rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  in_valid   in   1          in_data holds a sample
//  in_ready   out  1          block can accept a sample
//  in_data    in   WIDTH      sample, unsigned
//  out_valid  out  1          result registers valid
//  out_ready  in   1          consumer takes result
//  out_max    out  WIDTH      frame maximum
//  out_gt     out  N          bit k = 1 iff sample k == out_max
//  out_idx    out  clog2(N)   lowest k with out_gt[k] = 1
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; in_ready, out_valid, out_max, out_gt,
//    out_idx, sample counter, running max and mask all 0. Partial frame is discarded.
//  - in_ready is registered. It goes to 1 on the first clk edge after rst_n release and is
//    1 in IDLE/COLLECT, 0 in HOLD.
//  - Accept = in_valid & in_ready. The counter k indexes accepted samples 0..N-1.
//  - k=0: max <= in_data, mask <= 1<<0. State IDLE->COLLECT.
//  - k>0: in_data > max -> max <= in_data, mask <= 1<<k.
//         in_data == max -> mask |= 1<<k.
//         else no change.
//  - Comparison is unsigned, full WIDTH; no wrap. All-equal frame -> out_gt all ones, idx 0.
//  - The accept with k = N-1 loads the out_* registers on the same edge with the final values
//    (this sample included), sets out_valid=1 and in_ready=0, and moves to HOLD.
//    Latency: out_valid is high 1 cycle after the last accept.
//  - HOLD: out_* stable while out_valid & !out_ready. On out_valid & out_ready: out_valid <= 0,
//    in_ready <= 1, counter <= 0, state IDLE. Next frame accepted from the following cycle.
//    No bypass and no overlap between frames.
//  - in_valid with in_ready=0 is ignored; the source must hold it.
//  - Counter wraps N-1 -> 0 only via the HOLD handshake.
//  - States: IDLE (k=0, ready) -> COLLECT (0<k<N) -> HOLD (result) -> IDLE.
//    N accepts in a row: IDLE->COLLECT on the first, COLLECT->HOLD on the last.
//  - out_max/out_gt/out_idx retain their last values after handshake until next frame result.
// CONFIGURATION
//  - SERIAL_MAX_TRACKER_MIN_EN defined:
//    - adds output out_min [WIDTH] (frame minimum, same timing as out_max, reset 0)
//      and output out_lt [N] (bit k = 1 iff sample k == out_min).
//    - Tie rules mirror the max path.
//  - SERIAL_MAX_TRACKER_MIN_EN undefined: those ports and their logic are absent.
//    Max-path behaviour is identical in both builds.
// STRUCTURE
//  - Shared package cmp_pkg:
//    - state encodings ST_IDLE=2'd0, ST_COLLECT=2'd1, ST_HOLD=2'd2.
//    - clog2 constant function, reused by the comparator family.
//  - One sub-module: lowest_bit_index #(N): N-bit mask -> clog2(N) index of lowest set bit;
//    output 0 for an all-zero mask. Instantiated for out_idx
//    (and for the min index path if that is ever added).
// TESTING
//  1. Reset mid-frame: send 3,9 then pulse rst_n low. All outputs 0, in_ready=0.
//     Next frame 1,2,3,4 -> max 4, gt 1000, idx 3.
//  2. Frame 5,12,7,12 -> out_max=12, out_gt=4'b1010, out_idx=1.
//     out_valid high exactly 1 cycle after the 4th accept.
//  3. Frame 0,0,0,0 -> max 0, gt 1111, idx 0. Frame 15,15,14,0 -> max 15, gt 0011, idx 0.
//  4. Backpressure: hold out_ready=0 for 10 cycles with in_valid=1.
//     in_ready stays 0 and out_* stay stable. Release: out_valid drops next cycle, and the
//     next sample is accepted the cycle after.
//  5. Bubbles: random in_valid gaps within frame 8,3,8,1 -> same result as a gapless frame
//     (gt 0101, idx 0).
//  6. MIN_EN build: frame 6,2,9,2 -> max 9 (gt 0100), min 2, out_lt=4'b1010.

Source files
------------

// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared state encodings and helpers for the comparator family
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/lowest_bit_index.sv
// rtl/lowest_bit_index.sv - index of the lowest set bit of an N-bit mask (0 when empty)
module lowest_bit_index
  import cmp_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          mask,
  output logic [clog2(N)-1:0]   idx
);

  localparam int IW = clog2(N);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/serial_max_tracker.sv
// rtl/serial_max_tracker.sv - frame-wise running max over a sample stream with tie mask and lowest index
// Optional min path enabled by SERIAL_MAX_TRACKER_MIN_EN.
module serial_max_tracker
  import cmp_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_max,
  output logic [N-1:0]         out_gt,
`ifdef SERIAL_MAX_TRACKER_MIN_EN
  output logic [WIDTH-1:0]     out_min,
  output logic [N-1:0]         out_lt,
`endif
  output logic [clog2(N)-1:0]  out_idx
);

  localparam int IW = clog2(N);
  localparam logic [N-1:0]  ONE    = N'(1);
  localparam logic [IW-1:0] K_LAST = IW'(N - 1);

  state_t            state;
  logic [IW-1:0]     k;
  logic [WIDTH-1:0]  run_max, max_n;
  logic [N-1:0]      mask, mask_n, bit_k;
  logic [IW-1:0]     idx_n;
  logic              accept, first, last;

  assign accept = in_valid & in_ready;
  assign first  = (k == '0);
  assign last   = (k == K_LAST);
  assign bit_k  = ONE << k;

  // Next running max/mask with the current sample folded in; first sample restarts both.
  always_comb begin
    max_n  = run_max;
    mask_n = mask;
    if (first) begin
      max_n  = in_data;
      mask_n = bit_k;
    end else if (in_data > run_max) begin
      max_n  = in_data;
      mask_n = bit_k;
    end else if (in_data == run_max) begin
      mask_n = mask | bit_k;
    end
  end

  lowest_bit_index #(.N(N)) u_idx (
    .mask (mask_n),
    .idx  (idx_n)
  );

`ifdef SERIAL_MAX_TRACKER_MIN_EN
  logic [WIDTH-1:0]  run_min, min_n;
  logic [N-1:0]      lmask, lmask_n;

  always_comb begin
    min_n   = run_min;
    lmask_n = lmask;
    if (first) begin
      min_n   = in_data;
      lmask_n = bit_k;
    end else if (in_data < run_min) begin
      min_n   = in_data;
      lmask_n = bit_k;
    end else if (in_data == run_min) begin
      lmask_n = lmask | bit_k;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_min <= '0;
      lmask   <= '0;
      out_min <= '0;
      out_lt  <= '0;
    end else if (accept) begin
      run_min <= min_n;
      lmask   <= lmask_n;
      if (state == ST_COLLECT && last) begin
        out_min <= min_n;
        out_lt  <= lmask_n;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      k         <= '0;
      run_max   <= '0;
      mask      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_max   <= '0;
      out_gt    <= '0;
      out_idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            run_max <= max_n;
            mask    <= mask_n;
            k       <= k + IW'(1);
            state   <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            run_max <= max_n;
            mask    <= mask_n;
            if (last) begin
              out_max   <= max_n;
              out_gt    <= mask_n;
              out_idx   <= idx_n;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= ST_HOLD;
            end else begin
              k <= k + IW'(1);
            end
          end
        end
        ST_HOLD: begin
          // Result registers are left untouched so they read back until the next frame.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            k         <= '0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          k        <= '0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_max_tracker.sv
// tb/tb_serial_max_tracker.sv - directed self-checking bench for serial_max_tracker
module tb_serial_max_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       in_ready, out_valid;
  logic [3:0] out_max, out_gt;
  logic [1:0] out_idx;
`ifdef SERIAL_MAX_TRACKER_MIN_EN
  logic [3:0] out_min, out_lt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_max_tracker #(.WIDTH(4), .N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_gt    (out_gt),
`ifdef SERIAL_MAX_TRACKER_MIN_EN
    .out_min   (out_min),
    .out_lt    (out_lt),
`endif
    .out_idx   (out_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input string tag, input logic [15:0] f, input int gap);
    for (int i = 0; i < 4; i++) begin
      if (gap > 0) repeat ($urandom_range(0, gap)) @(posedge clk);
      #1;
      send(f[4*i +: 4]);
      if (i == 2) chk({tag, "_valid_early"}, 32'(out_valid), 32'd0);
    end
    chk({tag, "_valid_latency"}, 32'(out_valid), 32'd1);
  endtask

  task automatic expect_result(input string tag, input logic [3:0] mx,
                               input logic [3:0] gt, input logic [1:0] idx);
    chk({tag, "_max"}, 32'(out_max), 32'(mx));
    chk({tag, "_gt"},  32'(out_gt),  32'(gt));
    chk({tag, "_idx"}, 32'(out_idx), 32'(idx));
  endtask

  task automatic recv(input string tag);
    int n;
    n = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk({tag, "_recv_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    expect_result("rst", 4'd0, 4'b0000, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // 1. Reset mid-frame discards the partial frame
    send(4'd3);
    send(4'd9);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("midrst_in_ready",  32'(in_ready),  32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    expect_result("midrst", 4'd0, 4'b0000, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame("t1", {4'd4, 4'd3, 4'd2, 4'd1}, 0);
    expect_result("t1", 4'd4, 4'b1000, 2'd3);
    recv("t1");

    // 2. Ties at the max, 4. backpressure on the held result
    send_frame("t2", {4'd12, 4'd7, 4'd12, 4'd5}, 0);
    expect_result("t2", 4'd12, 4'b1010, 2'd1);
    in_valid = 1'b1;
    in_data  = 4'd7;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_max",       32'(out_max),   32'd12);
      chk("bp_gt",        32'(out_gt),    32'b1010);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_valid_drop", 32'(out_valid), 32'd0);
    chk("bp_ready_back", 32'(in_ready),  32'd1);
    chk("bp_max_retain", 32'(out_max),   32'd12);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    send(4'd1);
    send(4'd2);
    chk("t4_valid_early", 32'(out_valid), 32'd0);
    send(4'd3);
    chk("t4_valid_latency", 32'(out_valid), 32'd1);
    expect_result("t4", 4'd7, 4'b0001, 2'd0);
    recv("t4");

    // 3. All-equal zeros and a top-value tie
    send_frame("t3a", {4'd0, 4'd0, 4'd0, 4'd0}, 0);
    expect_result("t3a", 4'd0, 4'b1111, 2'd0);
    recv("t3a");
    send_frame("t3b", {4'd0, 4'd14, 4'd15, 4'd15}, 0);
    expect_result("t3b", 4'd15, 4'b0011, 2'd0);
    recv("t3b");

    // 5. Bubbles inside the frame
    send_frame("t5", {4'd1, 4'd8, 4'd3, 4'd8}, 3);
    expect_result("t5", 4'd8, 4'b0101, 2'd0);

    // Reset while a result is held clears the result registers
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("holdrst_out_valid", 32'(out_valid), 32'd0);
    expect_result("holdrst", 4'd0, 4'b0000, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef SERIAL_MAX_TRACKER_MIN_EN
    // 6. Min path
    send_frame("t6", {4'd2, 4'd9, 4'd2, 4'd6}, 0);
    expect_result("t6", 4'd9, 4'b0100, 2'd2);
    chk("t6_min", 32'(out_min), 32'd2);
    chk("t6_lt",  32'(out_lt),  32'b1010);
    recv("t6");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
